// File: rtl/hazard_forw_ctrl.sv
// rtl/hazard_forw_ctrl.sv - EXE operand forwarding, load-use and multicycle hazard control
module hazard_forw_ctrl #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int MC_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NUM_SRC*AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]    id_src_used,
    input  logic                  id_mc_op,
    input  logic [NUM_SRC*AW-1:0] exe_src_addr,
    input  logic [AW-1:0]         exe_reg_rd,
    input  logic                  exe_reg_write,
    input  logic                  exe_mem_read,
    input  logic                  exe_mc_start,
    input  logic [AW-1:0]         mem_reg_rd,
    input  logic                  mem_reg_write,
    input  logic [AW-1:0]         wb_reg_rd,
    input  logic                  wb_reg_write,
    output logic [2*NUM_SRC-1:0]  exe_forw_sel,
    output logic                  stall_id,
    output logic                  flush_exe,
    output logic                  mc_busy,
    output logic                  mc_done
);

    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [AW-1:0]   mc_rd_q;
    logic            mc_busy_q;
    logic            mc_done_q;

    logic [2*NUM_SRC-1:0] fwd_sel;
    logic [NUM_SRC-1:0]   lu_hit;
    logic [NUM_SRC-1:0]   mc_hit;
    logic                 lu_haz;
    logic                 mc_haz;
    logic                 hazard;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            logic [AW-1:0] exe_src;
            logic [AW-1:0] id_src;
            logic          mem_hit;
            logic          wb_hit;

            assign exe_src = exe_src_addr[i*AW +: AW];
            assign id_src  = id_src_addr[i*AW +: AW];

            // Each stage is qualified only by its own write enable; r0 is hardwired zero.
            assign mem_hit = mem_reg_write && (mem_reg_rd != '0) && (mem_reg_rd == exe_src);
            assign wb_hit  = wb_reg_write && (wb_reg_rd != '0) && (wb_reg_rd == exe_src);

            assign fwd_sel[2*i +: 2] = mem_hit ? 2'b10 :
                                       wb_hit  ? 2'b01 : 2'b00;

            assign lu_hit[i] = id_src_used[i] && (id_src == exe_reg_rd);
            assign mc_hit[i] = id_src_used[i] && (id_src == mc_rd_q);
        end
    endgenerate

    assign lu_haz = exe_mem_read && exe_reg_write && (exe_reg_rd != '0) && (|lu_hit);
    assign mc_haz = (state == MC_WAIT) && (id_mc_op || ((mc_rd_q != '0) && (|mc_hit)));
    assign hazard = lu_haz || mc_haz;

    // Combinational outputs are gated by reset so they drop immediately with arst_n.
    assign exe_forw_sel = arst_n ? fwd_sel : '0;
    assign stall_id     = arst_n && hazard;
    assign flush_exe    = arst_n && hazard;
    assign mc_busy      = mc_busy_q;
    assign mc_done      = mc_done_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= RUN;
            count     <= '0;
            mc_rd_q   <= '0;
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    mc_done_q <= 1'b0;
                    if (exe_mc_start) begin
                        state     <= MC_WAIT;
                        mc_rd_q   <= exe_reg_rd;
                        count     <= CW'(MC_LAT - 1);
                        mc_busy_q <= 1'b1;
                    end
                end
                MC_WAIT: begin
                    // A second start while busy is dropped: the in-flight op owns the unit.
                    if (count == '0) begin
                        state     <= RUN;
                        mc_busy_q <= 1'b0;
                        mc_done_q <= 1'b0;
                    end else begin
                        count     <= count - CW'(1);
                        mc_done_q <= (count == CW'(1));
                    end
                end
                default: begin
                    state     <= RUN;
                    mc_busy_q <= 1'b0;
                    mc_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_forw_ctrl.sv
// tb/tb_hazard_forw_ctrl.sv - scoreboard bench for hazard_forw_ctrl
module tb_hazard_forw_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [NS*AW-1:0]  id_src_addr;
    logic [NS-1:0]     id_src_used;
    logic              id_mc_op;
    logic [NS*AW-1:0]  exe_src_addr;
    logic [AW-1:0]     exe_reg_rd;
    logic              exe_reg_write;
    logic              exe_mem_read;
    logic              exe_mc_start;
    logic [AW-1:0]     mem_reg_rd;
    logic              mem_reg_write;
    logic [AW-1:0]     wb_reg_rd;
    logic              wb_reg_write;
    logic [2*NS-1:0]   exe_forw_sel;
    logic              stall_id;
    logic              flush_exe;
    logic              mc_busy;
    logic              mc_done;

    typedef struct packed {
        logic [3:0] sel;
        logic       stall;
        logic       flush;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    string chk_name;
    int   total = 0;
    int   bad = 0;

    hazard_forw_ctrl #(.AW(AW), .NUM_SRC(NS), .MC_LAT(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_mc_op(id_mc_op),
        .exe_src_addr(exe_src_addr), .exe_reg_rd(exe_reg_rd), .exe_reg_write(exe_reg_write),
        .exe_mem_read(exe_mem_read), .exe_mc_start(exe_mc_start),
        .mem_reg_rd(mem_reg_rd), .mem_reg_write(mem_reg_write),
        .wb_reg_rd(wb_reg_rd), .wb_reg_write(wb_reg_write),
        .exe_forw_sel(exe_forw_sel), .stall_id(stall_id), .flush_exe(flush_exe),
        .mc_busy(mc_busy), .mc_done(mc_done)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per presented sample, away from the rising edge.
    always @(negedge clk) begin
        if (chk_req) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s: no expectation queued", chk_name);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (exe_forw_sel !== e.sel || stall_id !== e.stall || flush_exe !== e.flush ||
                    mc_busy !== e.busy || mc_done !== e.done) begin
                    bad++;
                    $display("FAIL %s: got sel=%b stall=%b flush=%b busy=%b done=%b want sel=%b stall=%b flush=%b busy=%b done=%b",
                             chk_name, exe_forw_sel, stall_id, flush_exe, mc_busy, mc_done,
                             e.sel, e.stall, e.flush, e.busy, e.done);
                end
            end
        end
    end

    task automatic cyc(input string name, input logic [3:0] sel, input logic stall,
                       input logic busy, input logic done);
        exp_t e;
        e.sel = sel; e.stall = stall; e.flush = stall; e.busy = busy; e.done = done;
        exp_q.push_back(e);
        chk_name = name;
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_src_addr = '0; id_src_used = '0; id_mc_op = 1'b0;
        exe_src_addr = '0; exe_reg_rd = '0; exe_reg_write = 1'b0;
        exe_mem_read = 1'b0; exe_mc_start = 1'b0;
        mem_reg_rd = '0; mem_reg_write = 1'b0; wb_reg_rd = '0; wb_reg_write = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0;
        clr();
        // Hazardous inputs held during reset: outputs must still read zero.
        exe_src_addr = {5'd0, 5'd5}; mem_reg_rd = 5'd5; mem_reg_write = 1'b1;
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_reg_rd = 5'd3;
        id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01;
        cyc("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        arst_n = 1'b1;
        clr();
        cyc("idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // MEM over WB priority, then fallbacks
        exe_src_addr = {5'd0, 5'd5};
        mem_reg_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_rd = 5'd5; wb_reg_write = 1'b1;
        cyc("fwd_mem_prio", 4'b0010, 1'b0, 1'b0, 1'b0);
        mem_reg_write = 1'b0;
        cyc("fwd_wb", 4'b0001, 1'b0, 1'b0, 1'b0);
        wb_reg_rd = 5'd0;
        cyc("fwd_wb_r0", 4'b0000, 1'b0, 1'b0, 1'b0);

        // r0 and per-stage write enables on source 1
        clr();
        exe_src_addr = {5'd7, 5'd0};
        mem_reg_rd = 5'd0; mem_reg_write = 1'b1; wb_reg_rd = 5'd7; wb_reg_write = 1'b0;
        cyc("fwd_r0_we", 4'b0000, 1'b0, 1'b0, 1'b0);
        wb_reg_write = 1'b1;
        cyc("fwd_src1_wb", 4'b0100, 1'b0, 1'b0, 1'b0);
        mem_reg_rd = 5'd7;
        cyc("fwd_src1_mem", 4'b1000, 1'b0, 1'b0, 1'b0);

        // Load-use
        clr();
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_reg_rd = 5'd3;
        id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01;
        cyc("lu_stall", 4'b0000, 1'b1, 1'b0, 1'b0);
        exe_mem_read = 1'b0; exe_reg_write = 1'b0; exe_reg_rd = 5'd0;
        mem_reg_rd = 5'd3; mem_reg_write = 1'b1; exe_src_addr = {5'd0, 5'd3};
        cyc("lu_release_mem_fwd", 4'b0010, 1'b0, 1'b0, 1'b0);
        clr();
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_reg_rd = 5'd3;
        id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b00;
        cyc("lu_unused", 4'b0000, 1'b0, 1'b0, 1'b0);
        id_src_addr = {5'd3, 5'd0}; id_src_used = 2'b10;
        cyc("lu_src1", 4'b0000, 1'b1, 1'b0, 1'b0);
        exe_reg_rd = 5'd0; id_src_addr = '0;
        cyc("lu_r0", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Multicycle op rd=9, with an ignored restart in cycle 2
        clr();
        exe_mc_start = 1'b1; exe_reg_rd = 5'd9; exe_reg_write = 1'b1;
        id_src_addr = {5'd0, 5'd9}; id_src_used = 2'b01;
        cyc("mc_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        exe_mc_start = 1'b0;
        cyc("mc_c1", 4'b0000, 1'b1, 1'b1, 1'b0);
        exe_mc_start = 1'b1; exe_reg_rd = 5'd4;
        cyc("mc_c2_restart", 4'b0000, 1'b1, 1'b1, 1'b0);
        exe_mc_start = 1'b0;
        cyc("mc_c3", 4'b0000, 1'b1, 1'b1, 1'b0);
        cyc("mc_c4_done", 4'b0000, 1'b1, 1'b1, 1'b1);
        cyc("mc_c5_release", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Multicycle op to r0: only id_mc_op stalls
        clr();
        exe_mc_start = 1'b1; exe_reg_rd = 5'd0;
        cyc("mc0_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        exe_mc_start = 1'b0; id_src_addr = '0; id_src_used = 2'b01;
        cyc("mc0_c1_r0", 4'b0000, 1'b0, 1'b1, 1'b0);
        id_mc_op = 1'b1;
        cyc("mc0_c2_mcop", 4'b0000, 1'b1, 1'b1, 1'b0);
        cyc("mc0_c3_mcop", 4'b0000, 1'b1, 1'b1, 1'b0);
        cyc("mc0_c4_done", 4'b0000, 1'b1, 1'b1, 1'b1);
        cyc("mc0_c5_run", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Simultaneous hazards, then reset mid-op
        clr();
        exe_mc_start = 1'b1; exe_reg_rd = 5'd9;
        cyc("mcr_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        exe_mc_start = 1'b0;
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_reg_rd = 5'd6;
        id_src_addr = {5'd6, 5'd9}; id_src_used = 2'b11;
        cyc("mcr_c1_both", 4'b0000, 1'b1, 1'b1, 1'b0);
        arst_n = 1'b0;
        cyc("mcr_c2_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        arst_n = 1'b1;
        clr();
        id_src_addr = {5'd0, 5'd9}; id_src_used = 2'b01;
        for (int k = 0; k < 4; k++) cyc("mcr_after", 4'b0000, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
